// File: rtl/mux_arb_2_1.sv
// -----------------------------------------------------------------------------
// mux_arb_2_1
// Sequential front end for the 2:1 select datapath. Two valid/ready packet
// sources are arbitrated round-robin. The winner keeps the grant until its last
// beat. The registered select line (sel) drives the downstream 2:1 mux. The
// winning channel's beats are registered into a single-entry output buffer.
//
// Ports
//   clk                 single clock, all state changes on posedge
//   rst_n               synchronous active-low reset
//   i0_valid/data/last  channel 0 beat in;   i0_ready out
//   i1_valid/data/last  channel 1 beat in;   i1_ready out
//   sel                 registered select (0 = ch0, 1 = ch1)
//   y_valid/data/last   output buffer beat;  y_ready in
// -----------------------------------------------------------------------------
module mux_arb_2_1 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i0_valid,
    input  logic [DW-1:0] i0_data,
    input  logic          i0_last,
    output logic          i0_ready,
    input  logic          i1_valid,
    input  logic [DW-1:0] i1_data,
    input  logic          i1_last,
    output logic          i1_ready,
    output logic          sel,
    output logic          y_valid,
    output logic [DW-1:0] y_data,
    output logic          y_last,
    input  logic          y_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic          prio_q, prio_d;
    logic          y_valid_q, y_valid_d;
    logic [DW-1:0] y_data_q, y_data_d;
    logic          y_last_q, y_last_d;

    logic          buf_free_s;
    logic          i0_ready_s;
    logic          i1_ready_s;
    logic          acc0_s;
    logic          acc1_s;

    // Ready/accept decode: depends only on state, buffer occupancy and y_ready,
    // never on the same channel's valid, so no combinational loop upstream.
    always_comb begin
        buf_free_s = ~y_valid_q | y_ready;
        i0_ready_s = rst_n & (state_q == ST_LOCK0) & buf_free_s;
        i1_ready_s = rst_n & (state_q == ST_LOCK1) & buf_free_s;
        acc0_s     = i0_valid & i0_ready_s;
        acc1_s     = i1_valid & i1_ready_s;
    end

    // Arbitration FSM: next state, select and round-robin priority.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (i0_valid & i1_valid) begin
                    // Tie: prio names the channel that wins.
                    if (prio_q) begin
                        state_d = ST_LOCK1;
                        sel_d   = 1'b1;
                    end else begin
                        state_d = ST_LOCK0;
                        sel_d   = 1'b0;
                    end
                end else if (i0_valid) begin
                    state_d = ST_LOCK0;
                    sel_d   = 1'b0;
                end else if (i1_valid) begin
                    state_d = ST_LOCK1;
                    sel_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK0: begin
                // The lock is held even when the owner drops valid mid-packet.
                if (acc0_s & i0_last) begin
                    state_d = ST_IDLE;
                    prio_d  = 1'b1;
                end else begin
                    state_d = ST_LOCK0;
                end
            end
            ST_LOCK1: begin
                if (acc1_s & i1_last) begin
                    state_d = ST_IDLE;
                    prio_d  = 1'b0;
                end else begin
                    state_d = ST_LOCK1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Single-entry output buffer: load on accept, empty on downstream take.
    always_comb begin
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        y_last_d  = y_last_q;
        if (acc0_s) begin
            y_valid_d = 1'b1;
            y_data_d  = i0_data;
            y_last_d  = i0_last;
        end else if (acc1_s) begin
            y_valid_d = 1'b1;
            y_data_d  = i1_data;
            y_last_d  = i1_last;
        end else if (y_valid_q & y_ready) begin
            y_valid_d = 1'b0;
        end else begin
            y_valid_d = y_valid_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            prio_q    <= 1'b0;
            y_valid_q <= 1'b0;
            y_data_q  <= {DW{1'b0}};
            y_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            prio_q    <= prio_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_last_q  <= y_last_d;
        end
    end

    assign i0_ready = i0_ready_s;
    assign i1_ready = i1_ready_s;
    assign sel      = sel_q;
    assign y_valid  = y_valid_q;
    assign y_data   = y_data_q;
    assign y_last   = y_last_q;

endmodule

// File: tb/tb_mux_arb_2_1.sv
module tb_mux_arb_2_1;

    logic       clk;
    logic       rst_n;
    logic       i0_valid, i0_last, i0_ready;
    logic [7:0] i0_data;
    logic       i1_valid, i1_last, i1_ready;
    logic [7:0] i1_data;
    logic       sel;
    logic       y_valid, y_last, y_ready;
    logic [7:0] y_data;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t src0[$];
    beat_t src1[$];
    beat_t exp_q[$];
    logic  hold0;
    int    total;
    int    bad;

    mux_arb_2_1 #(.DW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i0_valid (i0_valid),
        .i0_data  (i0_data),
        .i0_last  (i0_last),
        .i0_ready (i0_ready),
        .i1_valid (i1_valid),
        .i1_data  (i1_data),
        .i1_last  (i1_last),
        .i1_ready (i1_ready),
        .sel      (sel),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_last   (y_last),
        .y_ready  (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        if (src0.size() > 0 && !hold0) begin
            i0_valid = 1'b1; i0_data = src0[0].d; i0_last = src0[0].l;
        end else begin
            i0_valid = 1'b0; i0_data = 8'h00; i0_last = 1'b0;
        end
        if (src1.size() > 0) begin
            i1_valid = 1'b1; i1_data = src1[0].d; i1_last = src1[0].l;
        end else begin
            i1_valid = 1'b0; i1_data = 8'h00; i1_last = 1'b0;
        end
    endtask

    task automatic send(input int ch, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d; b.l = l;
        if (ch == 0) src0.push_back(b);
        else         src1.push_back(b);
        exp_q.push_back(b);
    endtask

    // One clock: scoreboard and handshake sampling on negedge, new drive after posedge.
    task automatic tick();
        logic  a0, a1;
        beat_t e;
        @(negedge clk);
        a0 = i0_valid & i0_ready & rst_n;
        a1 = i1_valid & i1_ready & rst_n;
        if (y_valid && y_ready && rst_n) begin
            if (exp_q.size() == 0) begin
                check_val("sb_extra", {23'd0, y_last, y_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("sb_data", {24'd0, y_data}, {24'd0, e.d});
                check_val("sb_last", {31'd0, y_last}, {31'd0, e.l});
            end
        end
        @(posedge clk);
        #1;
        if (a0) void'(src0.pop_front());
        if (a1) void'(src1.pop_front());
        drive_inputs();
    endtask

    task automatic wait_src(input int ch, input int n, input string tag);
        int k;
        k = 0;
        while (((ch == 0) ? src0.size() : src1.size()) != n && k < 50) begin
            tick();
            k++;
        end
        check_val(tag, {31'd0, ((ch == 0) ? src0.size() : src1.size()) == n}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((src0.size() + src1.size() + exp_q.size()) != 0 && k < 100) begin
            tick();
            k++;
        end
        check_val(tag, src0.size() + src1.size() + exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [8:0] vpat, spat;
        int         k;
        total = 0; bad = 0;
        hold0 = 1'b0;
        rst_n = 1'b0;
        y_ready = 1'b1;

        // T1 reset with both sources valid; the loaded packets become T2.
        for (int i = 0; i < 3; i++) send(0, 8'hA1 + 8'(i), (i == 2));
        for (int i = 0; i < 3; i++) send(1, 8'hB1 + 8'(i), (i == 2));
        drive_inputs();
        tick();
        tick();
        check_val("t1_y_valid", {31'd0, y_valid}, 32'd0);
        check_val("t1_sel", {31'd0, sel}, 32'd0);
        check_val("t1_i0_ready", {31'd0, i0_ready}, 32'd0);
        check_val("t1_i1_ready", {31'd0, i1_ready}, 32'd0);
        rst_n = 1'b1;

        // T2 tie: A1..A3, bubble, B1..B3.
        vpat = 9'd0; spat = 9'd0;
        for (int i = 0; i < 9; i++) begin
            tick();
            vpat = {vpat[7:0], y_valid};
            spat = {spat[7:0], sel};
        end
        check_val("t2_valid_pat", {23'd0, vpat}, {23'd0, 9'b011101110});
        check_val("t2_sel_pat", {23'd0, spat}, {23'd0, 9'b000011111});
        drain("t2_drain");

        // T3 backpressure mid-packet.
        for (int i = 0; i < 4; i++) send(0, 8'hC1 + 8'(i), (i == 3));
        drive_inputs();
        k = 0;
        while (!(y_valid && y_data == 8'hC2) && k < 20) begin
            tick();
            k++;
        end
        check_val("t3_reach", {24'd0, y_data}, 32'h0000_00C2);
        y_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t3_hold_data", {24'd0, y_data}, 32'h0000_00C2);
            check_val("t3_hold_valid", {31'd0, y_valid}, 32'd1);
            check_val("t3_i0_ready", {31'd0, i0_ready}, 32'd0);
        end
        y_ready = 1'b1;
        drain("t3_drain");

        // T4 lock held while ch0 drops valid and ch1 waits.
        for (int i = 0; i < 4; i++) send(0, 8'hD1 + 8'(i), (i == 3));
        drive_inputs();
        wait_src(0, 2, "t4_reach");
        send(1, 8'hE1, 1'b0);
        send(1, 8'hE2, 1'b1);
        hold0 = 1'b1;
        drive_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("t4_sel", {31'd0, sel}, 32'd0);
            check_val("t4_i1_ready", {31'd0, i1_ready}, 32'd0);
        end
        hold0 = 1'b0;
        drive_inputs();
        drain("t4_drain");

        // T5 lone requester, four single-beat packets.
        for (int i = 0; i < 4; i++) send(1, 8'h11 + 8'(i), 1'b1);
        drive_inputs();
        vpat = 9'd0; spat = 9'd0;
        for (int i = 0; i < 9; i++) begin
            tick();
            vpat = {vpat[7:0], y_valid};
            spat = {spat[7:0], sel};
        end
        check_val("t5_valid_pat", {23'd0, vpat}, {23'd0, 9'b010101010});
        check_val("t5_sel_pat", {23'd0, spat}, {23'd0, 9'b111111111});
        drain("t5_drain");

        // T6: a ch0 packet leaves ch1 owning the next tie, then reset mid ch1 packet.
        send(0, 8'h21, 1'b1);
        drive_inputs();
        drain("t6_pre_drain");
        send(1, 8'h31, 1'b0);
        begin
            beat_t b;
            b.d = 8'h32; b.l = 1'b0; src1.push_back(b);
            b.d = 8'h33; b.l = 1'b0; src1.push_back(b);
            b.d = 8'h34; b.l = 1'b1; src1.push_back(b);
        end
        drive_inputs();
        wait_src(1, 2, "t6_reach");
        rst_n = 1'b0;
        src1.delete();
        drive_inputs();
        tick();
        check_val("t6_y_valid", {31'd0, y_valid}, 32'd0);
        check_val("t6_sel", {31'd0, sel}, 32'd0);
        check_val("t6_i1_ready", {31'd0, i1_ready}, 32'd0);
        check_val("t6_sb_empty", exp_q.size(), 32'd0);
        rst_n = 1'b1;
        send(0, 8'h41, 1'b1);
        send(1, 8'h51, 1'b1);
        drive_inputs();
        tick();
        check_val("t6_tie_sel", {31'd0, sel}, 32'd0);
        check_val("t6_tie_i0_ready", {31'd0, i0_ready}, 32'd1);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
